// File: rtl/add_seq_arbiter.sv
// add_seq_arbiter
//
// Purpose:
//   Two requesters share one 4-bit ripple-carry adder. Each accepted
//   operation is a (4*NIBBLES)-bit add or subtract. It runs one nibble per
//   clock, least-significant nibble first, with the carry held in a
//   register between nibbles. Requests are granted round-robin. The
//   result comes back on a valid/ready channel tagged with the requester id.
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               synchronous active-low reset
//   reqN_valid          requester N has an operation pending (N = 0, 1)
//   reqN_ready          requester N is accepted this cycle (combinational, IDLE only)
//   reqN_a, reqN_b      requester N operands, W = 4*NIBBLES bits
//   reqN_sub            requester N: 1 = a - b, 0 = a + b
//   rsp_valid           result available (registered)
//   rsp_ready           consumer accepts result
//   rsp_id              requester that issued the result
//   rsp_sum             result modulo 2^W, held between responses
//   rsp_cout            final carry; for subtract 1 = no borrow
//   busy                high whenever an operation is in flight or held

module add_seq_rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

module add_seq_arbiter #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req0_sub,

    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    input  logic                   req1_sub,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [4*NIBBLES-1:0]   rsp_sum,
    output logic                   rsp_cout,

    output logic                   busy
);

    localparam int DATA_W = 4 * NIBBLES;
    localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic                ptr;        // 0: requester 0 wins a tie, 1: requester 1 wins

    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;       // already inverted for subtract
    logic                carry;
    logic [IDX_W-1:0]    idx;
    logic                op_id;
    logic [DATA_W-1:0]   result;
    logic [DATA_W-1:0]   result_next;

    logic                grant0;
    logic                grant1;
    logic                accept;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic                sel_sub;

    logic [IDX_W+1:0]    base;
    logic [3:0]          a_nib;
    logic [3:0]          b_nib;
    logic [3:0]          sum_nib;
    logic                cout_nib;

    // Arbitration: a sole valid requester always wins; on a tie the
    // pointer decides. Ready is only offered in IDLE and out of reset.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || !ptr);
        grant1     = req1_valid && (!req0_valid ||  ptr);
        req0_ready = (state == IDLE) && rst_n && grant0;
        req1_ready = (state == IDLE) && rst_n && grant1;
        accept     = req0_ready || req1_ready;
    end

    always_comb begin
        sel_a   = req1_ready ? req1_a   : req0_a;
        sel_b   = req1_ready ? req1_b   : req0_b;
        sel_sub = req1_ready ? req1_sub : req0_sub;
    end

    // Nibble select for the shared adder. Subtract is a + ~b + 1, with
    // the +1 entering through the carry register on the first nibble.
    always_comb begin
        base  = {idx, 2'b00};
        a_nib = op_a[base +: 4];
        b_nib = op_b[base +: 4];
    end

    add_seq_rca4 u_adder (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .sum  (sum_nib),
        .cout (cout_nib)
    );

    always_comb begin
        result_next              = result;
        result_next[base +: 4]   = sum_nib;
    end

    assign busy = (state != IDLE);

    // Operand and working registers: loaded on accept, advanced in RUN.
    // They carry no reset; their contents are only consumed while the
    // control FSM is in RUN, which reset always leaves.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a  <= sel_a;
            op_b  <= sel_sub ? ~sel_b : sel_b;
            carry <= sel_sub;
            idx   <= '0;
            op_id <= req1_ready;
        end else if (state == RUN) begin
            result <= result_next;
            carry  <= cout_nib;
            idx    <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    // Control FSM and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                        // Whoever was just served loses the next tie.
                        ptr   <= req0_ready;
                    end
                end
                RUN: begin
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_id    <= op_id;
                        // Last nibble is folded in here so rsp_sum only
                        // changes once per operation.
                        rsp_sum   <= result_next;
                        rsp_cout  <= cout_nib;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq_arbiter.sv
module tb_add_seq_arbiter;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_sub;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
    logic [W-1:0] rsp_sum;

    add_seq_arbiter #(.NIBBLES(NIBBLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Requester-side view: what each requester is presenting.
    bit [W-1:0] opa [2];
    bit [W-1:0] opb [2];
    bit         ops [2];
    bit         opv [2];
    int         pref = 0;     // requester that wins a tie next
    int         acc_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req0_valid = opv[0]; req0_a = opa[0]; req0_b = opb[0]; req0_sub = ops[0];
        req1_valid = opv[1]; req1_a = opa[1]; req1_b = opb[1]; req1_sub = ops[1];
    endtask

    // Reference: plain integer arithmetic on the whole operand.
    function automatic logic [W:0] model(input bit [W-1:0] a, input bit [W-1:0] b, input bit s);
        logic [W:0] r;
        if (s) r = {(a >= b), W'(a - b)};
        else   r = {1'b0, a} + {1'b0, b};
        return r;
    endfunction

    function automatic bit [W-1:0] rnd_op();
        bit [W-1:0] v;
        case ($urandom_range(0, 3))
            0:       v = '0;
            1:       v = '1;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Called at a negedge with inputs driven. Returns at the negedge after
    // the accept edge with g = observed grant, or g = -1 on timeout.
    task automatic wait_accept(output int g, output int exp_g);
        bit found = 0;
        exp_g = (opv[0] && opv[1]) ? pref : (opv[1] ? 1 : 0);
        g = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                chk("grant", 32'({req1_ready, req0_ready}), (exp_g == 1) ? 32'h2 : 32'h1);
                g     = req1_ready ? 1 : 0;
                pref  = 1 - exp_g;
                found = 1;
            end
            @(negedge clk);
        end
        if (found) acc_cyc = cyc;
        else chk("accept_timeout", 32'(req0_ready | req1_ready), 32'h1);
    endtask

    task automatic do_txn(input int bp, input bit refill, output int g);
        logic [W:0] exp;
        int         exp_g;
        int         n;
        rsp_ready = (bp == 0);
        wait_accept(g, exp_g);
        if (g < 0) return;
        exp = model(opa[exp_g], opb[exp_g], ops[exp_g]);
        if (refill) begin
            opa[exp_g] = rnd_op(); opb[exp_g] = rnd_op(); ops[exp_g] = 1'($urandom);
        end else begin
            opv[exp_g] = 0;
        end
        drive();
        n = 0;
        while (!rsp_valid && n < 20) begin
            #1;
            chk("busy_run", 32'(busy), 32'h1);
            chk("no_ready_run", 32'({req1_ready, req0_ready}), 32'h0);
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n + 1), 32'(NIBBLES + 1));
        chk("rsp_id", 32'(rsp_id), 32'(exp_g));
        chk("rsp_sum", 32'(rsp_sum), 32'(exp[W-1:0]));
        chk("rsp_cout", 32'(rsp_cout), 32'(exp[W]));
        chk("busy_done", 32'(busy), 32'h1);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            #1;
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_id", 32'(rsp_id), 32'(exp_g));
            chk("bp_sum", 32'(rsp_sum), 32'(exp[W-1:0]));
            chk("bp_cout", 32'(rsp_cout), 32'(exp[W]));
            chk("bp_no_ready", 32'({req1_ready, req0_ready}), 32'h0);
        end
        rsp_ready = 1;
        @(negedge clk);
        chk("rsp_drop", 32'(rsp_valid), 32'h0);
        chk("busy_idle", 32'(busy), 32'h0);
        chk("sum_hold", 32'(rsp_sum), 32'(exp[W-1:0]));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_id"}, 32'(rsp_id), 32'h0);
        chk({tag, "_sum"}, 32'(rsp_sum), 32'h0);
        chk({tag, "_cout"}, 32'(rsp_cout), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_ready"}, 32'({req1_ready, req0_ready}), 32'h0);
    endtask

    initial begin
        int g, eg, prev;

        // Reset with both requesters pending.
        rst_n = 0; rsp_ready = 0;
        opv[0] = 1; opa[0] = 16'h1234; opb[0] = 16'h0FCD; ops[0] = 0;
        opv[1] = 1; opa[1] = 16'hFFFF; opb[1] = 16'h0001; ops[1] = 0;
        drive();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1;
        pref  = 0;

        // Add on requester 0 (wins first after reset), then overflow on 1.
        do_txn(0, 0, g);
        chk("first_grant", 32'(g), 32'h0);
        do_txn(0, 0, g);
        opv[1] = 1; opa[1] = 16'h0005; opb[1] = 16'h0007; ops[1] = 1; drive();
        do_txn(0, 0, g);
        opv[1] = 1; opa[1] = 16'h0007; opb[1] = 16'h0005; ops[1] = 1; drive();
        do_txn(0, 0, g);

        // Backpressure with requester 1 waiting through DONE.
        opv[0] = 1; opa[0] = rnd_op(); opb[0] = rnd_op(); ops[0] = 1'($urandom);
        opv[1] = 1; opa[1] = rnd_op(); opb[1] = rnd_op(); ops[1] = 1'($urandom);
        drive();
        do_txn(3, 0, g);
        chk("bp_grant", 32'(g), 32'h0);
        prev = acc_cyc;
        do_txn(0, 0, g);
        chk("bp_accept_gap", 32'(acc_cyc - prev), 32'(NIBBLES + 2 + 3));

        // Contention: both valid continuously.
        opv[0] = 1; opa[0] = rnd_op(); opb[0] = rnd_op(); ops[0] = 1'($urandom);
        opv[1] = 1; opa[1] = rnd_op(); opb[1] = rnd_op(); ops[1] = 1'($urandom);
        drive();
        for (int i = 0; i < 6; i++) begin
            do_txn(0, 1, g);
            chk("rr_seq", 32'(g), 32'(i % 2));
            if (i > 0) chk("rr_gap", 32'(acc_cyc - prev), 32'(NIBBLES + 2));
            prev = acc_cyc;
        end

        // Randomized traffic; a pending requester keeps its operands.
        for (int i = 0; i < 30; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!opv[r]) begin
                    opv[r] = 1'($urandom);
                    opa[r] = rnd_op(); opb[r] = rnd_op(); ops[r] = 1'($urandom);
                end
            end
            if (!opv[0] && !opv[1]) opv[0] = 1;
            drive();
            do_txn($urandom_range(0, 2), 1'($urandom), g);
        end

        // Abort in the second RUN cycle.
        opv[0] = 0; opv[1] = 1; opa[1] = rnd_op(); opb[1] = rnd_op(); ops[1] = 0;
        drive();
        rsp_ready = 1;
        wait_accept(g, eg);
        opv[1] = 0; drive();
        @(negedge clk);
        rst_n = 0;
        opv[0] = 1; drive();
        @(negedge clk);
        #1;
        chk_reset_outputs("abort");
        pref = 0;
        rst_n = 1;
        opv[0] = 0; drive();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'h0);
        end

        // Next request after abort.
        opv[0] = 1; opa[0] = 16'hBEEF; opb[0] = 16'h1111; ops[0] = 1;
        opv[1] = 1; opa[1] = 16'h8000; opb[1] = 16'h8000; ops[1] = 0;
        drive();
        do_txn(0, 0, g);
        chk("post_abort_grant", 32'(g), 32'h0);
        do_txn(0, 0, g);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/add_seq_arbiter.md
# add_seq_arbiter

Shares a single 4-bit ripple-carry adder between two requesters and sequences it nibble-serially to perform NIBBLES×4-bit add/subtract operations. Each operation is granted by round-robin arbitration and executed one nibble per cycle, least-significant nibble first, through a registered carry. The result is returned on a valid/ready response channel tagged with the requester ID. It sits between requester logic and the shared adder datapath; the adder is instantiated inside this block.

## Interface

- NIBBLES, default 4: operand width in nibbles; W = 4*NIBBLES; legal range 1..16.

- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  W  requester 0 operands.
- req0_sub  in  1  requester 0: 1 = a−b, 0 = a+b.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that issued the result.
- rsp_sum  out  W  result, modulo 2^W.
- rsp_cout  out  1  final carry; for subtract, 1 = no borrow (a ≥ b unsigned).
- busy  out  1  high whenever state ≠ IDLE.

## Operation

- Exactly one 4-bit ripple-carry adder instance (a, b, cin → sum, cout) is shared. No second adder.
- FSM states:
  - IDLE: arbitrate.
  - RUN: one nibble per cycle.
  - DONE: hold response.
- IDLE:
  - If no valid, stay in IDLE.
  - Otherwise grant one requester. If only one is valid, grant it. If both are valid, grant the requester not granted last (round-robin pointer).
  - reqN_ready = 1 combinationally for the granted requester only, in IDLE only.
  - On handshake: capture a. Capture b, inverted if sub. Set carry register to sub. Set nibble index to 0. Record the ID. Update the pointer so the other requester has priority next. Go to RUN.
- RUN, each cycle:
  - Adder inputs: a[idx], b'[idx], and the carry register.
  - Write the sum nibble into result[idx]. Load the adder cout into the carry register. Increment idx.
  - At idx = NIBBLES−1, go to DONE.
- DONE:
  - rsp_valid = 1; rsp_cout = final carry.
  - When rsp_ready = 1, go to IDLE.
  - No new request is accepted in DONE or RUN.
- Requester rules:
  - A requester holds valid and its operands stable until it sees ready.
  - The block samples operands only in the handshake cycle.
  - A requester that drops valid before ready loses nothing.
- Reset values (rst_n low at a rising edge):
  - State IDLE. Pointer prefers requester 0.
  - rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_cout = 0, busy = 0.
  - req0_ready = req1_ready = 0 while rst_n is low.
- Reset mid-operation aborts the operation. No response is ever produced for it.

## Timing

- Accept at edge k (IDLE, valid && ready).
  - RUN occupies cycles k+1 .. k+NIBBLES.
  - rsp_valid is high from cycle k+NIBBLES+1.
- Latency from accept to rsp_valid: NIBBLES+1 cycles (5 for default).
- Minimum issue interval with rsp_ready held high: NIBBLES+2 cycles (IDLE, NIBBLES×RUN, DONE).
- rsp_valid, rsp_id, rsp_sum and rsp_cout are registered. They are held stable while rsp_valid && !rsp_ready.
- rsp_valid deasserts the cycle after the rsp_ready handshake.
- rsp_sum keeps its last value in IDLE and RUN.
- Round-robin pointer:
  - It changes only on an accept handshake.
  - A sole valid requester is granted every time, regardless of the pointer.
- NIBBLES = 1: a single RUN cycle, latency 2.

## Test plan

- Reset: assert rst_n=0 for 2 cycles with both valids high. Required: all outputs 0, no ready, busy=0. After release, requester 0 is granted first.
- Add: req0 0x1234 + 0x0FCD. Required: req0_ready in the accept cycle, busy for the operation, rsp_valid exactly 5 cycles after accept, rsp_sum=0x2201, rsp_cout=0, rsp_id=0.
- Overflow and subtract on req1:
  - 0xFFFF + 0x0001 → 0x0000, cout=1.
  - 0x0005 − 0x0007 → 0xFFFE, cout=0.
  - 0x0007 − 0x0005 → 0x0002, cout=1.
  - All three return rsp_id=1.
- Contention: both valid continuously with rsp_ready=1 for 6 operations. Required: grants alternate 0,1,0,1,0,1. Accepts are spaced exactly 6 cycles apart. rsp_id matches each grant.
- Backpressure: hold rsp_ready=0 for 3 cycles in DONE with req1 valid. Required: response fields stable, no req1_ready. Accept occurs in the IDLE cycle after the rsp handshake.
- Abort: pull rst_n low for one cycle during the second RUN cycle. Required: no rsp_valid for that operation. Outputs return to reset values. The next request completes correctly.
